// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable sequence detector.
//   mode_e : behaviour once the full pattern has been seen
//   sym_at : extract symbol k from a packed pattern (symbol 0 in the LSBs)
package seq_detect_pkg;

  typedef enum logic {MODE_RESTART = 1'b0, MODE_STICKY = 1'b1} mode_e;

  // Upper bounds for the generic symbol extractor; callers cast to real widths.
  localparam int unsigned PAT_MAX_W = 256;
  localparam int unsigned SYM_MAX_W = 32;

  // Symbol k of a pattern whose symbols are sym_w bits wide.
  function automatic logic [SYM_MAX_W-1:0] sym_at(input logic [PAT_MAX_W-1:0] pattern,
                                                   input int unsigned sym_w,
                                                   input int unsigned k);
    logic [PAT_MAX_W-1:0] mask;
    mask = (PAT_MAX_W'(1) << sym_w) - PAT_MAX_W'(1);
    return SYM_MAX_W'((pattern >> (k * sym_w)) & mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear to zero (wins over inc)
//   inc        : add one unless already at all-ones
//   count      : registered count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Programmable Moore sequence detector with restart-only fallback.
//   clk, reset                         : clock, synchronous active-high reset
//   in_valid, in                       : qualified input symbol stream
//   cfg_load, cfg_pattern, cfg_sticky  : runtime pattern/mode load (restarts progress)
//   cnt_clr                            : clear match_count
//   out                                : progress index (registered Moore state)
//   match                              : registered, high while progress == SEQ_LEN
//   match_count                        : saturating count of completed matches
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int unsigned                SYM_W           = 2,
  parameter int unsigned                SEQ_LEN         = 3,
  parameter int unsigned                CNT_W           = 8,
  parameter logic [SEQ_LEN*SYM_W-1:0]   DEFAULT_PATTERN = 6'b111001,
  parameter logic                       DEFAULT_STICKY  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [SYM_W-1:0]               in,
  input  logic                           cfg_load,
  input  logic [SEQ_LEN*SYM_W-1:0]       cfg_pattern,
  input  logic                           cfg_sticky,
  input  logic                           cnt_clr,
  output logic [$clog2(SEQ_LEN+1)-1:0]   out,
  output logic                           match,
  output logic [CNT_W-1:0]               match_count
);

  localparam int unsigned P_W   = $clog2(SEQ_LEN + 1);
  localparam int unsigned PAT_W = SEQ_LEN * SYM_W;

  logic [PAT_W-1:0] pat_q;
  mode_e            mode_q;
  logic [P_W-1:0]   p_q;
  logic [P_W-1:0]   p_nx;
  logic             full;
  logic             hit_cur;
  logic             hit_first;
  logic             hit_last;
  logic             inc;

  // Symbol compares against the stored pattern and the next progress value.
  always_comb begin
    full      = (p_q == P_W'(SEQ_LEN));
    hit_cur   = (in == SYM_W'(sym_at(PAT_MAX_W'(pat_q), SYM_W, 32'(p_q))));
    hit_first = (in == SYM_W'(sym_at(PAT_MAX_W'(pat_q), SYM_W, 0)));
    hit_last  = (in == SYM_W'(sym_at(PAT_MAX_W'(pat_q), SYM_W, SEQ_LEN - 1)));
    p_nx      = p_q;
    if (!full) begin
      if (hit_cur) begin
        p_nx = p_q + P_W'(1);
      end else begin
        p_nx = hit_first ? P_W'(1) : P_W'(0);
      end
    end else if (!((mode_q == MODE_STICKY) && hit_last)) begin
      p_nx = hit_first ? P_W'(1) : P_W'(0);
    end
    // Only the final-symbol step into S_SEQ_LEN counts; sticky holds do not.
    inc = in_valid && !cfg_load && (p_q == P_W'(SEQ_LEN - 1)) && hit_cur;
  end

  // Progress state, registered match flag and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      match  <= 1'b0;
      pat_q  <= DEFAULT_PATTERN;
      mode_q <= mode_e'(DEFAULT_STICKY);
    end else if (cfg_load) begin
      p_q    <= '0;
      match  <= 1'b0;
      pat_q  <= cfg_pattern;
      mode_q <= mode_e'(cfg_sticky);
    end else if (in_valid) begin
      p_q    <= p_nx;
      match  <= (p_nx == P_W'(SEQ_LEN));
    end
  end

  assign out = p_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (inc),
    .count (match_count)
  );

endmodule
